// File: rtl/uart_tx_packet_scheduler_if.sv
// Bundle of request, transmitter-handshake and status signals for uart_tx_packet_scheduler.
// The master modport is the scheduler side; the slave modport is the requester/transmitter side.
interface uart_tx_packet_scheduler_if;
   logic        enable;
   logic [2:0]  req_valid;
   logic [23:0] req_payload;
   logic [2:0]  req_ack;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        pkt_done;
   logic        err_timeout;
   logic [1:0]  last_grant;

   modport master (
      input  enable,
      input  req_valid,
      input  req_payload,
      input  tx_ready,
      output req_ack,
      output tx_data,
      output tx_valid,
      output busy,
      output pkt_done,
      output err_timeout,
      output last_grant
   );

   modport slave (
      output enable,
      output req_valid,
      output req_payload,
      output tx_ready,
      input  req_ack,
      input  tx_data,
      input  tx_valid,
      input  busy,
      input  pkt_done,
      input  err_timeout,
      input  last_grant
   );
endinterface

// File: rtl/uart_tx_packet_scheduler.sv
// Arbitrates 3 requesters and frames each grant as HEADER/type/payload/csum bytes to a UART TX.
// Define TXSCHED_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module uart_tx_packet_scheduler #(
   parameter logic [7:0]  HEADER         = 8'hAA,
   parameter logic [7:0]  TYPE_BASE      = 8'h10,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic                        clk,
   input logic                        rst_n,
   uart_tx_packet_scheduler_if.master sched_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  byte_idx_q;
   logic [1:0]  idx_q;
   logic [7:0]  type_q;
   logic [7:0]  payload_q;
   logic [7:0]  csum_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic [2:0]  req_ack_q;
   logic        pkt_done_q;
   logic        err_timeout_q;
   logic        busy_q;
   logic [1:0]  last_grant_q;
   logic [15:0] tmo_cnt_q;

   logic        grant_vld_d;
   logic [1:0]  grant_idx_d;
   logic [7:0]  next_byte_d;

   // Padded to 4 entries so a 2-bit index never selects outside the array.
   logic [7:0]  payload_w [4];
   logic [7:0]  type_w    [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_req
      if (gi < 3) begin : g_real
         assign payload_w[gi] = sched_if.req_payload[8*gi +: 8];
      end else begin : g_pad
         assign payload_w[gi] = 8'h00;
      end
      assign type_w[gi] = TYPE_BASE + 8'(gi);
   end

`ifdef TXSCHED_RR_EN
   logic [1:0] rr_start;
   logic [1:0] rr_cand [3];

   assign rr_start = (last_grant_q >= 2'd2) ? 2'd0 : last_grant_q + 2'd1;

   // rr_cand[k] is the k-th index visited when searching from rr_start.
   for (genvar gi = 0; gi < 3; gi++) begin : g_rr
      logic [2:0] sum;
      assign sum          = {1'b0, rr_start} + 3'(gi);
      assign rr_cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   end

   always_comb begin
      grant_vld_d = |sched_if.req_valid;
      grant_idx_d = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (sched_if.req_valid[rr_cand[k]]) begin
            grant_idx_d = rr_cand[k];
         end
      end
   end
`else
   always_comb begin
      grant_vld_d = |sched_if.req_valid;
      grant_idx_d = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (sched_if.req_valid[k]) begin
            grant_idx_d = 2'(k);
         end
      end
   end
`endif

   always_comb begin
      next_byte_d = HEADER;
      case (byte_idx_q)
         2'd0:    next_byte_d = HEADER;
         2'd1:    next_byte_d = type_q;
         2'd2:    next_byte_d = payload_q;
         default: next_byte_d = csum_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         byte_idx_q    <= 2'd0;
         idx_q         <= 2'd0;
         type_q        <= 8'h00;
         payload_q     <= 8'h00;
         csum_q        <= 8'h00;
         tx_data_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
         req_ack_q     <= 3'b000;
         pkt_done_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         last_grant_q  <= 2'd2;
         tmo_cnt_q     <= 16'd0;
      end else begin
         req_ack_q     <= 3'b000;
         pkt_done_q    <= 1'b0;
         err_timeout_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (sched_if.enable && grant_vld_d) begin
                  idx_q        <= grant_idx_d;
                  type_q       <= type_w[grant_idx_d];
                  payload_q    <= payload_w[grant_idx_d];
                  csum_q       <= type_w[grant_idx_d] + payload_w[grant_idx_d];
                  last_grant_q <= grant_idx_d;
                  byte_idx_q   <= 2'd0;
                  tx_data_q    <= HEADER;
                  tx_valid_q   <= 1'b1;
                  busy_q       <= 1'b1;
                  tmo_cnt_q    <= 16'd0;
                  state_q      <= SEND;
               end
            end

            SEND: begin
               if (sched_if.tx_ready) begin
                  tmo_cnt_q  <= 16'd0;
                  tx_valid_q <= 1'b0;
                  if (byte_idx_q == 2'd3) begin
                     pkt_done_q <= 1'b1;
                     req_ack_q  <= 3'b001 << idx_q;
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     byte_idx_q <= byte_idx_q + 2'd1;
                     state_q    <= GAP;
                  end
               end else if (tmo_cnt_q == TMO_LAST) begin
                  // Stalled too long: drop the packet, leave the request pending.
                  tmo_cnt_q     <= 16'd0;
                  tx_valid_q    <= 1'b0;
                  err_timeout_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end

            GAP: begin
               tx_data_q  <= next_byte_d;
               tx_valid_q <= 1'b1;
               state_q    <= SEND;
            end

            default: begin
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign sched_if.req_ack     = req_ack_q;
   assign sched_if.tx_data     = tx_data_q;
   assign sched_if.tx_valid    = tx_valid_q;
   assign sched_if.busy        = busy_q;
   assign sched_if.pkt_done    = pkt_done_q;
   assign sched_if.err_timeout = err_timeout_q;
   assign sched_if.last_grant  = last_grant_q;

endmodule

// File: doc/uart_tx_packet_scheduler.md
Name: uart_tx_packet_scheduler

Overview:
- Sits between the main processor's command/report sources and the UART transmitter that drives the co-processor link.
- Arbitrates among 3 requesters and frames each granted request as a 4-byte packet: header, type, payload, checksum.
- Sequences the bytes into the transmitter over a valid/ready byte handshake.
- Recovers from a stalled transmitter with a timeout.

Parameters:
- HEADER, 8'hAA, first byte of every packet.
- TYPE_BASE, 8'h10, type byte = TYPE_BASE + requester index (mod 256).
- TIMEOUT_CYCLES, 65535, maximum consecutive cycles a byte may wait for tx_ready. Legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  when low, no new grants are made; a packet in flight still completes
- req_valid  in  3  request per requester; held high until the matching req_ack
- req_payload  in  24  payload byte of requester i on [8i+7:8i]
- req_ack  out  3  one-cycle pulse to the served requester when its packet completes
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter can accept a byte
- busy  out  1  high whenever the state is not IDLE
- pkt_done  out  1  one-cycle pulse when the checksum byte has been accepted
- err_timeout  out  1  one-cycle pulse when a packet is aborted
- last_grant  out  2  index of the most recent grant

Behaviour:
- Reset values: state IDLE; req_ack=0, tx_data=0, tx_valid=0, busy=0, pkt_done=0, err_timeout=0, last_grant=2, timeout counter 0. All outputs are registered.
- Reset mid-packet: tx_valid clears immediately (asynchronous). The packet is dropped and no ack is issued.
- States: IDLE, SEND, GAP.
- IDLE:
  - If enable=1 and any req_valid bit is set at edge N, the scheduler grants one requester.
  - At the grant it latches the requester index and that requester's payload, computes type = TYPE_BASE + idx and csum = (type + payload) mod 256, and updates last_grant.
  - In cycle N+1 the state is SEND, with tx_valid=1 and tx_data=HEADER.
- SEND:
  - A byte transfers on any cycle where tx_valid=1 and tx_ready=1.
  - After a transfer of byte 0, 1 or 2: state GAP for one cycle with tx_valid=0, then SEND with the next byte.
  - Byte order: HEADER, type, payload, csum.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - The transmitter must drop tx_ready within 1 cycle of accepting a byte.
- Completion: after the csum byte transfers, the next cycle has pkt_done=1, the granted req_ack bit=1, and state IDLE. The earliest next grant is visible the cycle after that.
- With tx_ready tied high and the grant at edge N:
  - header in N+1, type in N+3, payload in N+5, csum in N+7;
  - pkt_done and req_ack in N+8.
- Payload sampling: payload is sampled only at the grant; later changes to req_payload are ignored. If req_valid drops mid-packet, the packet still completes and is still acked.
- Timeout:
  - The counter increments each SEND cycle with tx_valid=1 and tx_ready=0, and clears on every transfer.
  - When the counter reaches TIMEOUT_CYCLES-1 with tx_ready still 0, the packet aborts: next cycle tx_valid=0, err_timeout=1, state IDLE, no req_ack.
  - The requester remains pending and is re-arbitrated normally.
  - If tx_ready=1 in that same cycle, the transfer wins and there is no timeout.
- enable: if enable falls during SEND or GAP, the packet finishes. IDLE then holds until enable=1.
- Arbitration without the optional feature: fixed priority, index 0 highest.

Optional Feature:
- Macro: TXSCHED_RR_EN.
- Defined: round-robin arbitration. Search starts at (last_grant+1) mod 3 and wraps, so after reset index 0 is searched first.
- Undefined: fixed priority 0 > 1 > 2, and last_grant is still reported.

Test Plan:
- Single request, tx_ready=1: req_valid=3'b001, payload[7:0]=8'h55 at edge N.
  - tx_data bytes are AA, 10, 55, 65 in cycles N+1, N+3, N+5, N+7.
  - pkt_done and req_ack=3'b001 in N+8.
- Backpressure: tx_ready low for 5 cycles during the type byte.
  - tx_data holds 8'h10 with tx_valid=1.
  - The byte transfers on the first tx_ready=1 cycle; no bytes are duplicated or skipped.
- Contention: req_valid=3'b111 held across 3 packets.
  - Fixed priority: types 10, 10, 10.
  - With TXSCHED_RR_EN: types 10, 11, 12.
- Timeout: TIMEOUT_CYCLES=8, tx_ready=0 forever after the header request.
  - err_timeout pulses exactly once, tx_valid=0 after it, no req_ack.
  - Raising tx_ready then yields the full packet and ack.
- Reset mid-packet during the payload byte: all outputs return to reset values; after release the pending request is re-sent from the header.
- Checksum wrap: requester 2, payload 8'hF5 gives type 8'h12 and csum 8'h07.
